serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 10 +
 rtl/serial_adder_fa_bit.sv | 13 +
 rtl/serial_adder.sv | 122 ++++++++++++
 tb/tb_serial_adder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
package serial_adder_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_fa_bit.sv
// One-bit full adder: the single arithmetic slice reused every cycle by serial_adder.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit add/subtract: LSB first through one full-adder slice and a carry flop,
// with a start/ready/done handshake. Results are held until the next completion.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int            CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    sa_state_t        state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             fa_s, fa_co;

    fa_bit u_fa (
        .a  (opa_q[0]),
        .b  (opb_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no branch can leave one unassigned and infer a latch.
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
                    opa_d   = a;
                    opb_d   = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d   = {fa_s, acc_q[WIDTH-1:1]};
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    // On the last bit opa_q[0]/opb_q[0] are the operand MSBs (B possibly inverted).
                    sum_d   = {fa_s, acc_q[WIDTH-1:1]};
                    cout_d  = fa_co;
                    ovf_d   = (opa_q[0] == opb_q[0]) && (fa_s != opa_q[0]);
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses <= so every register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ready    = (state_q != RUN);
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=2 against an arithmetic reference model.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       start8, cin8, sub8, ready8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;
    logic       start2, cin2, sub2, ready2, busy2, done2, cout2, ovf2;
    logic [1:0] a2, b2, sum2;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2), .sub(sub2),
        .ready(ready2), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .overflow(ovf2)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] last8 = 8'h00;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    // Reference: plain integer add/subtract, signed range test for overflow, a>=b for no-borrow.
    function automatic res_t model(input longint unsigned a, input longint unsigned b,
                                   input logic cin, input logic sub, input int w);
        res_t m;
        longint unsigned mask, full;
        longint sa, sb, r, smax, smin;
        mask = (64'd1 << w) - 64'd1;
        sa   = (((a >> (w - 1)) & 64'd1) != 0) ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb   = (((b >> (w - 1)) & 64'd1) != 0) ? longint'(b) - (longint'(1) << w) : longint'(b);
        smax = (longint'(1) << (w - 1)) - 1;
        smin = -(longint'(1) << (w - 1));
        if (sub) begin
            m.sum  = (a - b) & mask;
            m.cout = (a >= b);
            r      = sa - sb;
        end else begin
            full   = a + b + {63'd0, cin};
            m.sum  = full & mask;
            m.cout = ((full >> w) & 64'd1) != 0;
            r      = sa + sb + longint'(cin);
        end
        m.ovf = (r > smax) || (r < smin);
        return m;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Enter and leave at a falling edge; start is sampled at the following rising edge.
    task automatic run8(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic sb,
                        input logic [7:0] es, input logic eco, input logic eov);
        int   lat;
        logic rdy_ok, hold_ok;
        a8 = a; b8 = b; cin8 = ci; sub8 = sb; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0; a8 = ~a; b8 = ~b; cin8 = ~ci; sub8 = ~sb;
        rdy_ok  = (ready8 === 1'b0) && (busy8 === 1'b1);
        hold_ok = (sum8 === last8);
        lat     = 0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done8 === 1'b1) begin
                lat = n;
                break;
            end
            if (ready8 !== 1'b0 || busy8 !== 1'b1) rdy_ok = 1'b0;
            if (sum8 !== last8) hold_ok = 1'b0;
        end
        check({name, "_latency"}, 64'(lat), 64'd8);
        check({name, "_ready_low"}, {63'd0, rdy_ok}, 64'd1);
        check({name, "_sum_held"}, {63'd0, hold_ok}, 64'd1);
        check({name, "_sum"}, {56'd0, sum8}, {56'd0, es});
        check({name, "_cout"}, {63'd0, cout8}, {63'd0, eco});
        check({name, "_ovf"}, {63'd0, ovf8}, {63'd0, eov});
        last8 = es;
        @(posedge clk);
        @(negedge clk);
        check({name, "_done_pulse"}, {62'd0, done8, ready8}, 64'b01);
    endtask

    task automatic run2(input string name, input logic [1:0] a, input logic [1:0] b,
                        input logic ci, input logic sb,
                        input logic [1:0] es, input logic eco, input logic eov);
        int lat;
        a2 = a; b2 = b; cin2 = ci; sub2 = sb; start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0;
        lat    = 0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done2 === 1'b1) begin
                lat = n;
                break;
            end
        end
        check({name, "_latency"}, 64'(lat), 64'd2);
        check({name, "_result"}, {59'd0, sum2, cout2, ovf2}, {59'd0, es, eco, eov});
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        res_t m;
        logic [7:0] ra, rb;
        logic rc, rs;
        logic seen_done;

        vecs[0] = '{8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
        vecs[2] = '{8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[4] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[5] = '{8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[7] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0; sub2 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("reset_8", {52'd0, sum8, cout8, ovf8, done8, busy8}, {52'd0, 8'h00, 4'b0000});
        check("reset_ready_8", {63'd0, ready8}, 64'd1);
        check("reset_2", {57'd0, sum2, cout2, ovf2, done2, busy2, ready2}, {57'd0, 2'b00, 5'b00001});

        foreach (vecs[i])
            run8($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                 vecs[i].s, vecs[i].co, vecs[i].ov);

        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            m  = model({56'd0, ra}, {56'd0, rb}, rc, rs, 8);
            run8($sformatf("rnd%0d", i), ra, rb, rc, rs, m.sum[7:0], m.cout, m.ovf);
        end

        // Start while running is ignored; start held into DONE is accepted back-to-back.
        a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0; a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        a8 = 8'h11; b8 = 8'h22; sub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ignore_start_done", {55'd0, done8, sum8}, {55'd0, 1'b1, 8'h03});
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        check("b2b_accepted", {54'd0, done8, busy8, sum8}, {54'd0, 2'b01, 8'h03});
        last8 = 8'h03;
        begin
            int lat;
            lat = 0;
            for (int n = 1; n <= 30; n++) begin
                @(posedge clk);
                @(negedge clk);
                if (done8 === 1'b1) begin
                    lat = n;
                    break;
                end
            end
            check("b2b_latency", 64'(lat), 64'd8);
            check("b2b_sum", {56'd0, sum8}, 64'h33);
        end
        last8 = 8'h33;
        @(posedge clk);
        @(negedge clk);

        // Asynchronous reset mid-operation (counter at 4) abandons the operation.
        a8 = 8'h55; b8 = 8'h0F; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_reset_outputs", {52'd0, sum8, cout8, ovf8, done8, busy8}, 64'd0);
        check("midrun_reset_ready", {63'd0, ready8}, 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done8 !== 1'b0 || ready8 !== 1'b1) seen_done = 1'b1;
        end
        check("midrun_reset_no_done", {63'd0, seen_done}, 64'd0);
        last8 = 8'h00;
        run8("after_reset", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);

        run2("w2_spec", 2'b11, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 64; i++) begin
            logic [5:0] v;
            v = 6'(i);
            m = model({62'd0, v[1:0]}, {62'd0, v[3:2]}, v[4], v[5], 2);
            run2($sformatf("w2_%0d", i), v[1:0], v[3:2], v[4], v[5], m.sum[1:0], m.cout, m.ovf);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
